// File: rtl/vrf_pkg.sv
// Shared vector-register-file definitions for the vector load writeback path.
// Holds register/element widths, the writeback FSM state type and the tail-mask helper.
// Pure declarations: no logic, no clocking.
package vrf_pkg;

  localparam int VREG_ADDR_W = 5;
  localparam int ELEM_W      = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } vld_state_e;

  // Tail-mask bit for element idx: set when idx lies below vl. Callers only ask
  // about idx < ELEMENTS, so a vl above ELEMENTS clamps naturally to all-ones.
  function automatic logic in_tail(input int unsigned idx, input int unsigned vl);
    return (idx < vl);
  endfunction

endpackage

// File: rtl/vld_elem_writer_if.sv
// Bundle of the command, mask, memory-response and element-write signals of vld_elem_writer.
// master = the writeback block; slave = its environment (LSU, memory response path, VRF).
// Ports: cmd_* load command, mask_src/mask VRF v0 read, rsp_* response words, el_wr_* element write, busy/busy_vd/done status.
interface vld_elem_writer_if
  import vrf_pkg::*;
#(
  parameter int ELEMENTS = 8,
  parameter int VL_W     = $clog2(ELEMENTS) + 1
);

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [VREG_ADDR_W-1:0]       cmd_vd;
  logic [VL_W-1:0]              cmd_vl;
  logic                         cmd_vm;
  logic [VREG_ADDR_W-1:0]       mask_src;
  logic [ELEMENTS-1:0]          mask;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ELEM_W-1:0]            rsp_data;
  logic [ELEMENTS-1:0]          el_wr_en;
  logic [VREG_ADDR_W-1:0]       el_wr_addr;
  logic [ELEMENTS*ELEM_W-1:0]   el_wr_data;
  logic                         busy;
  logic [VREG_ADDR_W-1:0]       busy_vd;
  logic                         done;

  modport master (
    input  cmd_valid, cmd_vd, cmd_vl, cmd_vm, mask, rsp_valid, rsp_data,
    output cmd_ready, mask_src, rsp_ready, el_wr_en, el_wr_addr, el_wr_data,
           busy, busy_vd, done
  );

  modport slave (
    output cmd_valid, cmd_vd, cmd_vl, cmd_vm, mask, rsp_valid, rsp_data,
    input  cmd_ready, mask_src, rsp_ready, el_wr_en, el_wr_addr, el_wr_data,
           busy, busy_vd, done
  );

endinterface

// File: rtl/vld_lowest_set.sv
// Priority encoder: index of the lowest set bit of vec, plus a valid flag.
// Latency: purely combinational.
// Backpressure: none. Ports: vec in, idx out (0 when vec is empty), vld out (vec != 0).
module vld_lowest_set #(
  parameter int W     = 8,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    vld = |vec;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/vld_elem_writer.sv
// Vector-load writeback: scatters in-order response words into active element slots, then one element write.
// Latency: N active elements -> WRITE N+1 cycles after accept, done one cycle later (N+2 per load back-to-back).
// Backpressure: cmd_ready only in IDLE; rsp_ready only in COLLECT while active elements remain; rsp stalls hold state.
// Ports: clk, rst_n (sync, active-low), io (vld_elem_writer_if.master: cmd/mask/rsp in, el_wr/busy/done out).
module vld_elem_writer
  import vrf_pkg::*;
#(
  parameter int ELEMENTS = 8,
  parameter int VL_W     = $clog2(ELEMENTS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  vld_elem_writer_if.master io
);

  localparam int IDX_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

  vld_state_e                       state_q, state_d;
  logic [ELEMENTS-1:0]              pending_q, pending_d;
  logic [ELEMENTS-1:0]              active_q, active_d;
  logic [ELEMENTS-1:0][ELEM_W-1:0]  buf_q, buf_d;
  logic [VREG_ADDR_W-1:0]           vd_q, vd_d;
  logic                             done_q, done_d;

  logic [ELEMENTS-1:0]              cmd_tail;
  logic [ELEMENTS-1:0]              cmd_active;
  logic [IDX_W-1:0]                 lo_idx;
  logic                             lo_vld;
  logic                             cmd_fire;
  logic                             rsp_fire;

  // Active set is fixed at accept: later changes to v0 do not affect this load.
  always_comb begin
    cmd_tail = '0;
    for (int k = 0; k < ELEMENTS; k++) begin
      cmd_tail[k] = in_tail(k, 32'(io.cmd_vl));
    end
    cmd_active = cmd_tail & (io.cmd_vm ? {ELEMENTS{1'b1}} : io.mask);
  end

  assign cmd_fire = io.cmd_valid && (state_q == IDLE);
  assign rsp_fire = io.rsp_valid && io.rsp_ready;

  // Responses arrive in element order, so each word lands in the lowest still-pending slot.
  vld_lowest_set #(
    .W     (ELEMENTS),
    .IDX_W (IDX_W)
  ) u_lowest (
    .vec (pending_q),
    .idx (lo_idx),
    .vld (lo_vld)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    buf_d     = buf_q;
    vd_d      = vd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          active_d  = cmd_active;
          pending_d = cmd_active;
          vd_d      = io.cmd_vd;
          buf_d     = '0;
          // Nothing to collect (vl=0 or fully masked): still issue a zero-enable write.
          state_d   = (cmd_active != '0) ? COLLECT : WRITE;
        end
      end
      COLLECT: begin
        if (rsp_fire && lo_vld) begin
          buf_d[lo_idx]     = io.rsp_data;
          pending_d[lo_idx] = 1'b0;
          if (pending_d == '0) state_d = WRITE;
        end else if (pending_q == '0) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      active_q  <= '0;
      buf_q     <= '0;
      vd_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      buf_q     <= buf_d;
      vd_q      <= vd_d;
      done_q    <= done_d;
    end
  end

  assign io.cmd_ready  = (state_q == IDLE);
  assign io.rsp_ready  = (state_q == COLLECT) && (pending_q != '0);
  assign io.el_wr_en   = (state_q == WRITE) ? active_q : '0;
  assign io.el_wr_addr = vd_q;
  assign io.el_wr_data = buf_q;
  assign io.busy       = (state_q != IDLE);
  assign io.busy_vd    = vd_q;
  assign io.done       = done_q;
  assign io.mask_src   = '0;

endmodule

// File: tb/tb_vld_elem_writer.sv
// Self-checking bench for vld_elem_writer: directed vector table, random loads against a
// behavioural model, and a hand-written reset-mid-collect sequence.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vld_elem_writer;
  import vrf_pkg::*;

  localparam int E   = 8;
  localparam int VLW = $clog2(E) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vld_elem_writer_if #(.ELEMENTS(E), .VL_W(VLW)) bus ();

  vld_elem_writer #(.ELEMENTS(E), .VL_W(VLW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: element k is active when it is below min(vl,E) and either
  // unmasked or its v0 bit is set; the j-th response word goes to the j-th active element.
  function automatic logic [E-1:0] model_active(input int vl, input logic vm, input logic [E-1:0] m);
    logic [E-1:0] a;
    int n;
    a = '0;
    n = (vl > E) ? E : vl;
    for (int k = 0; k < n; k++) a[k] = vm | m[k];
    return a;
  endfunction

  function automatic logic [E*32-1:0] model_data(input logic [E-1:0] a, input logic [31:0] base);
    logic [E*32-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int k = 0; k < E; k++) begin
      if (a[k]) begin
        d[32*k +: 32] = base + 32'(j);
        j++;
      end
    end
    return d;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_ready"},  256'(bus.cmd_ready),  256'(1));
    chk({tag, " rsp_ready"},  256'(bus.rsp_ready),  256'(0));
    chk({tag, " el_wr_en"},   256'(bus.el_wr_en),   256'(0));
    chk({tag, " el_wr_addr"}, 256'(bus.el_wr_addr), 256'(0));
    chk({tag, " el_wr_data"}, 256'(bus.el_wr_data), 256'(0));
    chk({tag, " busy"},       256'(bus.busy),       256'(0));
    chk({tag, " busy_vd"},    256'(bus.busy_vd),    256'(0));
    chk({tag, " done"},       256'(bus.done),       256'(0));
    chk({tag, " mask_src"},   256'(bus.mask_src),   256'(0));
  endtask

  // Presents one command at the current falling edge and runs it to the done pulse.
  // Returns at the falling edge where done is high, so the next call is back-to-back.
  task automatic run_load(input string tag, input logic [4:0] vd, input int vl, input logic vm,
                          input logic [E-1:0] m, input int stall, input logic [31:0] base,
                          input logic [E-1:0] exp_en, input int exp_cyc);
    logic [E-1:0]    act;
    logic [E*32-1:0] exp_dat;
    logic [E-1:0]    wr_en;
    logic [4:0]      wr_addr;
    logic [E*32-1:0] wr_dat;
    int nact, nrsp, cyc, wr_seen, wr_cyc, done_cyc, n;
    act     = model_active(vl, vm, m);
    exp_dat = model_data(act, base);
    nact    = $countones(act);
    wr_en = '0; wr_addr = '0; wr_dat = '0;

    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " cmd_ready at issue"}, 256'(bus.cmd_ready), 256'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_vd    = vd;
    bus.cmd_vl    = VLW'(vl);
    bus.cmd_vm    = vm;
    bus.mask      = m;
    @(negedge clk);
    // Scramble command fields and v0 after accept; the load must be unaffected.
    bus.cmd_valid = 1'b0;
    bus.cmd_vd    = 5'($urandom);
    bus.cmd_vl    = VLW'($urandom);
    bus.mask      = ~m;

    cyc = 1; nrsp = 0; wr_seen = 0; wr_cyc = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 400) begin
      if (bus.busy) begin
        chk({tag, " cmd_ready while busy"}, 256'(bus.cmd_ready), 256'(0));
        chk({tag, " busy_vd"}, 256'(bus.busy_vd), 256'(vd));
      end
      if (bus.busy && !bus.rsp_ready) begin
        wr_seen++;
        wr_cyc  = cyc;
        wr_en   = bus.el_wr_en;
        wr_addr = bus.el_wr_addr;
        wr_dat  = bus.el_wr_data;
      end else begin
        chk({tag, " el_wr_en outside write"}, 256'(bus.el_wr_en), 256'(0));
      end
      if (bus.done) done_cyc = cyc;
      if (bus.rsp_ready) begin
        if (int'($urandom_range(99)) < stall) begin
          bus.rsp_valid = 1'b0;
          bus.rsp_data  = $urandom;
        end else begin
          bus.rsp_valid = 1'b1;
          bus.rsp_data  = base + 32'(nrsp);
          nrsp++;
        end
      end else begin
        bus.rsp_valid = 1'($urandom_range(1));
        bus.rsp_data  = $urandom;
      end
      if (done_cyc == 0) begin
        @(negedge clk);
        cyc++;
      end
    end

    chk({tag, " done seen"},     256'(done_cyc != 0), 256'(1));
    chk({tag, " rsp count"},     256'(nrsp),          256'(nact));
    chk({tag, " write cycles"},  256'(wr_seen),       256'(1));
    chk({tag, " el_wr_en"},      256'(wr_en),         256'(exp_en));
    chk({tag, " el_wr_addr"},    256'(wr_addr),       256'(vd));
    chk({tag, " el_wr_data"},    256'(wr_dat),        256'(exp_dat));
    chk({tag, " done after write"}, 256'(done_cyc),   256'(wr_cyc + 1));
    if (exp_cyc >= 0) chk({tag, " accept to done"}, 256'(done_cyc), 256'(exp_cyc));
  endtask

  typedef struct {
    logic [4:0]   vd;
    int           vl;
    logic         vm;
    logic [E-1:0] mask;
    int           stall;
    logic [31:0]  base;
    logic [E-1:0] exp_en;
    int           exp_cyc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [4:0]   r_vd;
    int           r_vl, r_stall, n;
    logic         r_vm;
    logic [E-1:0] r_m, r_act;
    logic [31:0]  r_base;

    vecs[0] = '{vd: 5'd3,  vl: 8,  vm: 1'b1, mask: 8'h00, stall: 0,  base: 32'h100,      exp_en: 8'hFF, exp_cyc: 10};
    vecs[1] = '{vd: 5'd5,  vl: 3,  vm: 1'b1, mask: 8'h00, stall: 0,  base: 32'h200,      exp_en: 8'h07, exp_cyc: 5};
    vecs[2] = '{vd: 5'd9,  vl: 8,  vm: 1'b0, mask: 8'hA5, stall: 0,  base: 32'hA0,       exp_en: 8'hA5, exp_cyc: 6};
    vecs[3] = '{vd: 5'd1,  vl: 0,  vm: 1'b1, mask: 8'hFF, stall: 0,  base: 32'h300,      exp_en: 8'h00, exp_cyc: 2};
    vecs[4] = '{vd: 5'd2,  vl: 8,  vm: 1'b0, mask: 8'h00, stall: 0,  base: 32'h400,      exp_en: 8'h00, exp_cyc: 2};
    vecs[5] = '{vd: 5'd4,  vl: 8,  vm: 1'b1, mask: 8'h00, stall: 50, base: 32'hDEAD0000, exp_en: 8'hFF, exp_cyc: -1};
    vecs[6] = '{vd: 5'd6,  vl: 15, vm: 1'b0, mask: 8'h3C, stall: 0,  base: 32'h600,      exp_en: 8'h3C, exp_cyc: 6};
    vecs[7] = '{vd: 5'd31, vl: 5,  vm: 1'b0, mask: 8'hFF, stall: 30, base: 32'h700,      exp_en: 8'h1F, exp_cyc: -1};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_vd    = '0;
    bus.cmd_vl    = '0;
    bus.cmd_vm    = 1'b0;
    bus.mask      = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle after reset");

    // Directed table, issued back-to-back in the done cycle of the previous load.
    for (int i = 0; i < 8; i++) begin
      run_load($sformatf("vec%0d", i), vecs[i].vd, vecs[i].vl, vecs[i].vm, vecs[i].mask,
               vecs[i].stall, vecs[i].base, vecs[i].exp_en, vecs[i].exp_cyc);
    end

    // Random loads against the model.
    for (int i = 0; i < 40; i++) begin
      r_vd    = 5'($urandom);
      r_vl    = int'($urandom_range(15));
      r_vm    = 1'($urandom_range(1));
      r_m     = E'($urandom);
      r_stall = (i % 4 == 0) ? 0 : int'($urandom_range(60));
      r_base  = $urandom;
      r_act   = model_active(r_vl, r_vm, r_m);
      run_load($sformatf("rnd%0d", i), r_vd, r_vl, r_vm, r_m, r_stall, r_base, r_act,
               (r_stall == 0) ? $countones(r_act) + 2 : -1);
    end

    // Reset in the middle of COLLECT after two of eight words.
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_vd    = 5'd7;
    bus.cmd_vl    = VLW'(8);
    bus.cmd_vm    = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("midrst rsp_ready", 256'(bus.rsp_ready), 256'(1));
    for (int w = 0; w < 2; w++) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'h5500 + 32'(w);
      @(negedge clk);
    end
    bus.rsp_valid = 1'b0;
    chk("midrst busy before reset", 256'(bus.busy), 256'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst in reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_reset_outputs($sformatf("midrst after reset c%0d", c));
    end
    run_load("post reset", 5'd3, 8, 1'b1, 8'h00, 0, 32'h100, 8'hFF, 10);

    // done is a single-cycle pulse.
    @(negedge clk);
    chk("done pulse width", 256'(bus.done), 256'(0));
    chk("idle cmd_ready", 256'(bus.cmd_ready), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
